// File: rtl/emulib_fifo_rr_arbiter.sv
// ---------------------------------------------------------------------------
// emulib_fifo_rr_arbiter
// Round-robin arbiter that merges NREQ burst requesters into one shared write
// FIFO. A burst is locked to its owner from its first beat until the beat
// marked req_last fires. Each FIFO word is tagged with the source id.
//
// Optional feature: define EMULIB_FIFO_ARB_STATS_EN to get per-requester
// accepted-beat counters on beat_cnt. When the macro is not defined,
// beat_cnt is tied to zero and no counter registers exist.
// ---------------------------------------------------------------------------
module emulib_fifo_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_last,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  fifo_winc,
  input  logic                  fifo_wfull,
  output logic [IDW+WIDTH-1:0]  fifo_wdata,
  output logic                  busy,
  output logic [NREQ*32-1:0]    beat_cnt
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [IDW-1:0]  owner_r;
  logic [IDW-1:0]  owner_s;
  logic [IDW-1:0]  last_grant_r;
  logic [IDW-1:0]  last_grant_s;

  logic [IDW-1:0]  sel_id_s;
  logic            sel_some_s;
  logic            sel_valid_s;
  logic            fire_s;

  // Pick the serviced requester: rotating search in IDLE, the owner in LOCKED
  always_comb begin
    sel_id_s   = '0;
    sel_some_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // Walk from farthest to nearest so the nearest valid requester
        // after last_grant is the one left in sel_id_s.
        for (int k = NREQ; k >= 1; k--) begin
          int  idx;
          logic hit;
          idx        = (int'(last_grant_r) + k) % NREQ;
          hit        = req_valid[idx];
          sel_id_s   = hit ? IDW'(idx) : sel_id_s;
          sel_some_s = sel_some_s | hit;
        end
      end
      ST_LOCKED: begin
        sel_id_s   = owner_r;
        sel_some_s = 1'b1;
      end
      default: begin
        sel_id_s   = '0;
        sel_some_s = 1'b0;
      end
    endcase
  end

  assign sel_valid_s = sel_some_s & req_valid[sel_id_s];
  // Outputs are forced quiet while reset is asserted.
  assign fifo_winc   = sel_valid_s & ~rst;
  assign fire_s      = fifo_winc & ~fifo_wfull;
  assign fifo_wdata  = {sel_id_s, req_data[int'(sel_id_s)*WIDTH +: WIDTH]};
  assign busy        = (state_r == ST_LOCKED);

  // One-hot ready to the selected requester while the FIFO has room
  always_comb begin
    req_ready = '0;
    if (sel_some_s && !fifo_wfull && !rst) begin
      req_ready[sel_id_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Next-state logic: lock on a non-last beat, release on the owner's last beat
  always_comb begin
    state_s      = state_r;
    owner_s      = owner_r;
    last_grant_s = last_grant_r;
    case (state_r)
      ST_IDLE: begin
        if (fire_s && req_last[sel_id_s]) begin
          last_grant_s = sel_id_s;
        end else if (fire_s) begin
          state_s = ST_LOCKED;
          owner_s = sel_id_s;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (fire_s && req_last[owner_r]) begin
          state_s      = ST_IDLE;
          last_grant_s = owner_r;
        end else begin
          state_s = ST_LOCKED;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, owner and rotation pointer registers; reset gives requester 0 priority
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      owner_r      <= '0;
      last_grant_r <= IDW'(NREQ - 1);
    end else begin
      state_r      <= state_s;
      owner_r      <= owner_s;
      last_grant_r <= last_grant_s;
    end
  end

`ifdef EMULIB_FIFO_ARB_STATS_EN
  logic [31:0] cnt_r [NREQ];

  // Count accepted beats per requester, wrapping naturally at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) begin
        cnt_r[i] <= 32'd0;
      end
    end else if (fire_s) begin
      cnt_r[sel_id_s] <= cnt_r[sel_id_s] + 32'd1;
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_cnt
    assign beat_cnt[g*32 +: 32] = cnt_r[g];
  end
`else
  assign beat_cnt = '0;
`endif

endmodule

// File: tb/tb_emulib_fifo_rr_arbiter.sv
// ---------------------------------------------------------------------------
// Bench for emulib_fifo_rr_arbiter (NREQ=4, WIDTH=32). Directed stimulus
// pushes the expected {id, payload} of every beat into a queue; a monitor
// running alongside pops and compares whenever a beat lands in the FIFO.
// ---------------------------------------------------------------------------
module tb_emulib_fifo_rr_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_last;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  fifo_winc;
  logic                  fifo_wfull;
  logic [IDW+WIDTH-1:0]  fifo_wdata;
  logic                  busy;
  logic [NREQ*32-1:0]    beat_cnt;

  logic [IDW+WIDTH-1:0]  exp_q [$];
  logic [31:0]           pay [4];
  int                    tests = 0;
  int                    fails = 0;

  emulib_fifo_rr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_winc  (fifo_winc),
    .fifo_wfull (fifo_wfull),
    .fifo_wdata (fifo_wdata),
    .busy       (busy),
    .beat_cnt   (beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] id, input logic [31:0] d);
    exp_q.push_back({id, d});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor step, evaluated on each falling edge
  task automatic mon();
    if (!rst && fifo_winc && !fifo_wfull) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_fire: got %h expected no beat", fifo_wdata);
      end else begin
        chk("fire_data", 64'(fifo_wdata), 64'(exp_q.pop_front()));
      end
    end
  endtask

  // One reset cycle with all requesters valid; nothing may be accepted
  task automatic reset_dut();
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_winc", 64'(fifo_winc), 64'h0);
    step();
    rst       = 1'b0;
    req_valid = 4'b0000;
  endtask

  task automatic stimulus();
    rst        = 1'b1;
    req_valid  = 4'b0000;
    req_last   = 4'b0000;
    fifo_wfull = 1'b0;
    req_data   = {pay[3], pay[2], pay[1], pay[0]};
    step();
    reset_dut();
    @(negedge clk);
    chk("reset_busy", 64'(busy), 64'h0);
    for (int i = 0; i < NREQ; i++) chk("reset_cnt", 64'(beat_cnt[i*32 +: 32]), 64'h0);
    step();

    // Round robin over four single-beat requesters: 0,1,2,3,0
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      push(2'(k % 4), pay[k % 4]);
      @(negedge clk);
      chk("rr_ready", 64'(req_ready), 64'(4'b0001 << (k % 4)));
      step();
    end
    req_valid = 4'b0000;

    // Three-beat burst from req 1 while req 2 waits
    req_valid = 4'b0110;
    req_last  = 4'b0100;
    push(2'd1, pay[1]);
    @(negedge clk); chk("burst_busy0", 64'(busy), 64'h0); step();
    push(2'd1, pay[1]);
    @(negedge clk); chk("burst_busy1", 64'(busy), 64'h1);
    chk("burst_ready1", 64'(req_ready), 64'h2); step();
    req_last = 4'b0110;
    push(2'd1, pay[1]);
    @(negedge clk); chk("burst_busy2", 64'(busy), 64'h1);
    chk("burst_ready2", 64'(req_ready), 64'h2); step();
    req_valid = 4'b0100;
    push(2'd2, pay[2]);
    @(negedge clk); chk("after_busy", 64'(busy), 64'h0);
    chk("after_ready", 64'(req_ready), 64'h4); step();
    req_valid = 4'b0000;

    // Locked owner 1 under backpressure, others valid but never served
    req_valid = 4'b0010;
    req_last  = 4'b0000;
    push(2'd1, pay[1]);
    step();
    req_valid  = 4'b1011;
    fifo_wfull = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("full_winc", 64'(fifo_winc), 64'h1);
      chk("full_ready", 64'(req_ready), 64'h0);
      chk("full_busy", 64'(busy), 64'h1);
      chk("full_owner", 64'(fifo_wdata), 64'({2'd1, pay[1]}));
      step();
    end
    fifo_wfull = 1'b0;
    req_last   = 4'b1111;
    push(2'd1, pay[1]);
    @(negedge clk); chk("drop_ready", 64'(req_ready), 64'h2); step();
    push(2'd3, pay[3]); step();
    push(2'd0, pay[0]); step();
    req_valid = 4'b0000;

    // Full FIFO in IDLE: nothing fires, priority pointer stays
    req_valid  = 4'b0110;
    fifo_wfull = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("idle_full_winc", 64'(fifo_winc), 64'h1);
      chk("idle_full_data", 64'(fifo_wdata), 64'({2'd1, pay[1]}));
      chk("idle_full_ready", 64'(req_ready), 64'h0);
      step();
    end
    fifo_wfull = 1'b0;
    push(2'd1, pay[1]); step();
    req_valid = 4'b0000;

    // Reset in the middle of a burst from req 2
    req_valid = 4'b0100;
    req_last  = 4'b0000;
    push(2'd2, pay[2]); step();
    req_valid = 4'b0000;
    @(negedge clk); chk("mid_busy", 64'(busy), 64'h1); step();
    reset_dut();
    req_valid = 4'b1010;
    req_last  = 4'b1111;
    push(2'd1, pay[1]);
    @(negedge clk); chk("post_rst_busy", 64'(busy), 64'h0); step();
    push(2'd3, pay[3]); step();
    req_valid = 4'b0000;

    // Payload and id routed to the FIFO with zero latency
    req_data[2*32 +: 32] = 32'hDEAD_BEEF;
    req_valid = 4'b0100;
    push(2'd2, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("dbf_winc", 64'(fifo_winc), 64'h1);
    chk("dbf_data", 64'(fifo_wdata), 64'h2_DEAD_BEEF);
    step();
    req_valid = 4'b0000;
    req_data[2*32 +: 32] = pay[2];

    // Beat counters: 10 from req 3, 4 from req 0
    reset_dut();
    req_valid = 4'b1000;
    for (int k = 0; k < 10; k++) begin push(2'd3, pay[3]); step(); end
    req_valid = 4'b0001;
    for (int k = 0; k < 4; k++) begin push(2'd0, pay[0]); step(); end
    req_valid = 4'b0000;
    @(negedge clk);
`ifdef EMULIB_FIFO_ARB_STATS_EN
    chk("cnt0", 64'(beat_cnt[0 +: 32]), 64'd4);
    chk("cnt1", 64'(beat_cnt[32 +: 32]), 64'd0);
    chk("cnt2", 64'(beat_cnt[64 +: 32]), 64'd0);
    chk("cnt3", 64'(beat_cnt[96 +: 32]), 64'd10);
`else
    for (int i = 0; i < NREQ; i++) chk("cnt_off", 64'(beat_cnt[i*32 +: 32]), 64'h0);
`endif
    step();
    step();
  endtask

  initial begin
    pay[0] = 32'h1111_1111;
    pay[1] = 32'h2222_2222;
    pay[2] = 32'h3333_3333;
    pay[3] = 32'h4444_4444;
    fork
      begin
        forever begin
          @(negedge clk);
          mon();
        end
      end
      begin
        stimulus();
      end
    join_any
    chk("queue_empty", 64'(exp_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
